mont_digit_sequencer: RTL and testbench

MONT_DIGIT_SEQUENCER -- requirements
Module: mont_digit_sequencer

---
 rtl/mont_digit_sequencer.sv | 90 +++++++++
 tb/tb_mont_digit_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mont_digit_sequencer.sv
// Radix-4 digit sequencer for a Montgomery datapath: loads an operand and issues
// its 2-bit digits least-significant first over a valid/ready handshake.
module mont_digit_sequencer #(
  parameter int unsigned WIDTH  = 1028,
  parameter int unsigned DIGITS = WIDTH / 2,
  parameter int unsigned IW     = $clog2(DIGITS)
) (
  input  logic             clk,
  input  logic             restn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] operand,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic [1:0]       digit,
  output logic [IW-1:0]    digit_idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [IW-1:0] LastIdx = IW'(DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [IW-1:0]    cnt_q, cnt_d;

  logic in_issue;
  logic is_last;

  assign in_issue = (state_q == StIssue);
  assign is_last  = (cnt_q == LastIdx);

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    // Abort wins over start and over a transfer on the same edge.
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            opnd_d  = operand;
            cnt_d   = '0;
            state_d = StIssue;
          end
        end
        StIssue: begin
          if (digit_ready) begin
            if (is_last) begin
              // Counter holds at the final index instead of wrapping.
              state_d = StDone;
            end else begin
              opnd_d = {2'b00, opnd_q[WIDTH-1:2]};
              cnt_d  = cnt_q + 1'b1;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state_q <= StIdle;
      opnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign digit_valid = in_issue;
  assign digit       = in_issue ? opnd_q[1:0] : 2'b00;
  assign digit_idx   = in_issue ? cnt_q : '0;
  assign last        = in_issue && is_last;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_mont_digit_sequencer.sv
// Bench for mont_digit_sequencer: transaction-level model with per-cycle compare on an
// 8-bit instance, directed literal checks, and an all-ones run on a default-width instance.
module tb_mont_digit_sequencer;

  localparam int unsigned SW  = 8;
  localparam int unsigned SD  = SW / 2;
  localparam int unsigned SIW = $clog2(SD);
  localparam int unsigned BW  = 1028;
  localparam int unsigned BD  = BW / 2;
  localparam int unsigned BIW = $clog2(BD);

  logic clk = 1'b0;
  logic restn = 1'b1;

  logic          start = 1'b0, abort = 1'b0, digit_ready = 1'b0;
  logic [SW-1:0] operand = '0;
  logic          digit_valid, last, busy, done;
  logic [1:0]    digit;
  logic [SIW-1:0] digit_idx;

  logic          b_start = 1'b0, b_ready = 1'b0;
  logic [BW-1:0] b_operand = '0;
  logic          b_valid, b_last, b_busy, b_done;
  logic [1:0]    b_digit;
  logic [BIW-1:0] b_idx;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mont_digit_sequencer #(.WIDTH(SW)) u_dut (
    .clk(clk), .restn(restn), .start(start), .abort(abort), .operand(operand),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .digit(digit),
    .digit_idx(digit_idx), .last(last), .busy(busy), .done(done)
  );

  mont_digit_sequencer u_big (
    .clk(clk), .restn(restn), .start(b_start), .abort(1'b0), .operand(b_operand),
    .digit_valid(b_valid), .digit_ready(b_ready), .digit(b_digit),
    .digit_idx(b_idx), .last(b_last), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: phase 0 = idle, 1 = issuing digit m_k of m_op, 2 = completion cycle.
  int          m_phase = 0;
  int          m_k = 0;
  logic [SW-1:0] m_op = '0;

  always @(posedge clk or negedge restn) begin
    if (!restn) begin
      m_phase <= 0;
    end else if (abort) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_op    <= operand;
        m_k     <= 0;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (digit_ready) begin
        if (m_k == SD - 1) m_phase <= 2;
        else               m_k <= m_k + 1;
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    int exp_digit;
    exp_digit = (m_phase == 1) ? (int'(m_op >> (2 * m_k)) & 3) : 0;
    chk("m_valid", int'(digit_valid), int'(m_phase == 1));
    chk("m_digit", int'(digit), exp_digit);
    chk("m_idx",   int'(digit_idx), (m_phase == 1) ? m_k : 0);
    chk("m_last",  int'(last), int'(m_phase == 1 && m_k == SD - 1));
    chk("m_busy",  int'(busy), int'(m_phase != 0));
    chk("m_done",  int'(done), int'(m_phase == 2));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int k;
    #1 restn = 1'b0;
    step();
    step();
    chk("rst_valid", int'(digit_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(digit_idx), 0);
    restn = 1'b1;
    step();

    // Full-speed sequence of operand 11_10_01_00.
    operand = 8'hE4; start = 1'b1; digit_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("seq_valid", int'(digit_valid), 1);
      chk("seq_digit", int'(digit), i);
      chk("seq_idx", int'(digit_idx), i);
      chk("seq_last", int'(last), int'(i == 3));
      step();
    end
    chk("seq_done", int'(done), 1);
    chk("seq_done_busy", int'(busy), 1);
    chk("seq_done_valid", int'(digit_valid), 0);
    step();
    chk("seq_after_busy", int'(busy), 0);
    chk("seq_after_done", int'(done), 0);

    // Ready toggling: outputs hold while stalled.
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    for (int j = 0; j < 7; j++) begin
      digit_ready = (j % 2 == 0);
      chk("stall_digit", int'(digit), k);
      chk("stall_idx", int'(digit_idx), k);
      chk("stall_last", int'(last), int'(k == 3));
      step();
      if (j % 2 == 0) k++;
    end
    chk("stall_done", int'(done), 1);
    digit_ready = 1'b1;
    step();

    // Abort coincident with a transfer at idx 2.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_idx", int'(digit_idx), 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(digit_valid), 0);
    step();
    chk("abort_nodone", int'(done), 0);
    operand = 8'h1B; start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_idx", int'(digit_idx), 0);
    chk("restart_digit", int'(digit), 3);
    for (int i = 0; i < 5; i++) step();

    // Second start during issue is ignored.
    operand = 8'hE4; start = 1'b1;
    step();
    operand = 8'h1B;
    for (int i = 0; i < 4; i++) begin
      chk("ign_digit", int'(digit), i);
      step();
    end
    start = 1'b0;
    chk("ign_done", int'(done), 1);
    step();

    // Asynchronous reset between edges.
    start = 1'b1;
    step();
    start = 1'b0;
    digit_ready = 1'b0;
    #2 restn = 1'b0;
    #1;
    chk("arst_valid", int'(digit_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_digit", int'(digit), 0);
    chk("arst_idx", int'(digit_idx), 0);
    chk("arst_done", int'(done), 0);
    step();
    restn = 1'b1;
    digit_ready = 1'b1;
    step();
    step();
    chk("arst_idle", int'(busy), 0);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 600; c++) begin
      start       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 24) == 0);
      digit_ready = ($urandom_range(0, 2) != 0);
      operand     = SW'($urandom);
      restn       = ($urandom_range(0, 99) != 0);
      step();
    end
    start = 1'b0; abort = 1'b0; restn = 1'b1;
    step();

    // Default width, all-ones operand.
    b_operand = '1; b_ready = 1'b1; b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < int'(BD); i++) begin
      if (b_digit != 2'd3 || int'(b_idx) != i || b_last != (i == int'(BD) - 1) || !b_valid)
        chk("big_digit", i * 4 + int'(b_digit), i * 4 + 3);
      else
        chk("big_digit", int'(b_idx), i);
      step();
    end
    chk("big_done", int'(b_done), 1);
    step();
    chk("big_idle", int'(b_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
